if_fetch_unit: RTL and testbench
================================

Name: if_fetch_unit

Overview:
- Instruction fetch front end that produces the PC/instruction pair consumed by the IF/ID pipeline register, i.e. the upstream end of the fetch→decode interface.
- Owns the PC, issues req/ack fetches to instruction memory, and buffers returned words in a small queue.
- Obeys the same hazard (stall) and flush (branch redirect) controls as the IF/ID register: stalls hold the head entry, flushes drop queued and in-flight instructions and redirect the PC.

Parameters:
- DEPTH, 2, instruction queue entries (power of 2, ≥2)
- RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  asynchronous, active-low reset
- imem_req_o  out  1  fetch request, registered level
- imem_addr_o  out  32  fetch word address, bits[1:0]=0, stable while imem_req_o=1
- imem_ack_i  in  1  transfer completes on an edge where imem_req_o && imem_ack_i
- imem_data_i  in  32  instruction word, valid with imem_ack_i
- hazard_i  in  1  decode stall; head entry not consumed
- flush_i  in  1  redirect; kill queued and in-flight fetches
- target_i  in  32  redirect PC, sampled when flush_i=1
- valid_o  out  1  head entry present
- pc_o  out  32  head entry PC; 0 when empty
- inst_o  out  32  head entry instruction; 0 (NOP) when empty

Behaviour:
- Reset (async, rst_i=0):
  - imem_req_o=0, imem_addr_o=0, valid_o=0, pc_o=0, inst_o=0
  - queue count=0, fetch_pc=RESET_PC, state=IDLE
  - An abandoned in-flight request is not tracked; memory must tolerate it.
- States:
  - IDLE: no request outstanding.
  - REQ: request outstanding, response wanted.
  - KILL: request outstanding, response to be discarded.
- Space rule: a new request is issued only if count_next < DEPTH, where count_next = count + push − pop for this edge. At most one request is ever outstanding, so the queue never overflows.
- IDLE→REQ:
  - Taken on the edge where the space rule holds and flush_i=0.
  - Sets imem_req_o=1, imem_addr_o=fetch_pc.
- REQ, ack edge:
  - Push {fetch_pc, imem_data_i}; fetch_pc += 4 (wraps modulo 2^32).
  - If space remains, stay in REQ with imem_addr_o=new fetch_pc (back-to-back, one word per cycle at zero wait).
  - Otherwise imem_req_o=0 and go to IDLE.
- REQ, no ack: hold imem_req_o and imem_addr_o unchanged.
- Pop:
  - Occurs on an edge with valid_o=1, hazard_i=0, flush_i=0.
  - Head advances; outputs show the new head next cycle, or zeros if the queue is now empty.
- Latency: zero-wait memory gives first valid_o 2 cycles after reset release (request edge, then ack edge), then 1 instruction/cycle sustained.
- hazard_i=1: no pop; fetching continues until the queue is full, then imem_req_o drops.
- flush_i=1 (dominates hazard_i and ack), on the edge:
  - count=0, valid_o=0, pc_o=inst_o=0.
  - fetch_pc = {target_i[31:2], 2'b00}.
  - If REQ without ack: go to KILL, keep the request until ack, discard the data, then go to IDLE.
  - If REQ with ack on the same edge: discard the data, go to IDLE, imem_req_o=0.
  - If IDLE or KILL: enter or remain in IDLE or KILL respectively.
- KILL, ack edge: discard the data, imem_req_o=0, go to IDLE. The next request uses the redirected fetch_pc.
- A second flush during KILL only updates fetch_pc.
- Empty + hazard: outputs stay 0, no error.
- Pointers are log2(DEPTH) bits and wrap naturally; count is log2(DEPTH)+1 bits.

Decomposition:
- Shared package:
  - FETCH_STATE enum (IDLE, REQ, KILL)
  - NOP_INST=32'h0
  - PC_STEP=4
  - fetch_entry typedef {pc[31:0], inst[31:0]}
- Sub-module: fetch_queue (parameterised synchronous FIFO of fetch_entry with push, pop, clear, count; no overflow checking). FSM and PC logic stay in if_fetch_unit.

Test Plan:
- Reset release, ack tied to req, hazard_i=0 → addresses 0,4,8,… on consecutive cycles; pc_o=0 with inst_o=mem[0] two cycles after release, then one instruction per cycle.
- hazard_i held 4 cycles mid-stream → pc_o/inst_o frozen; queue fills to DEPTH=2; imem_req_o drops; resumes in order with no duplicates or skips.
- Ack delayed 3 cycles → imem_addr_o stable while imem_req_o=1; valid_o=0 with pc_o=inst_o=0 while the queue is empty.
- flush_i with target_i=32'h0000_0103 while a request is outstanding (ack 2 cycles later) → queue cleared same edge; in-flight data discarded; next request addr=32'h0000_0100.
- flush_i coincident with hazard_i and ack → flush wins; ack data not enqueued; valid_o=0; next fetch from the target.
- RESET_PC=32'hFFFF_FFF8, free-run → addresses FFFF_FFF8, FFFF_FFFC, 0000_0000; async rst_i mid-REQ clears imem_req_o immediately without a clock.

Source files
------------

// File: rtl/if_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch front end.
package if_fetch_unit_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    KILL = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INST = 32'h0000_0000;
  localparam logic [31:0] PC_STEP  = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/if_fetch_unit_fetch_queue.sv
// Small synchronous FIFO of fetched {pc, inst} pairs; head is presented from registers.
module if_fetch_unit_fetch_queue
  import if_fetch_unit_pkg::*;
#(
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  fetch_entry_t     entry_i,
  input  logic             pop_i,
  input  logic             clear_i,
  output logic [CNT_W-1:0] count_o,
  output logic             head_valid_o,
  output fetch_entry_t     head_o
);

  fetch_entry_t     mem_q [DEPTH];
  fetch_entry_t     mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             head_valid_q, head_valid_d;
  fetch_entry_t     head_q, head_d;

  // Next-state of storage and pointers; head is looked up from the post-edge view.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) begin
        mem_d[wr_ptr_q] = entry_i;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop_i) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
    end
    head_valid_d = (count_d != '0);
    head_d       = head_valid_d ? mem_d[rd_ptr_d] : '{pc: 32'h0, inst: NOP_INST};
  end

  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      head_valid_q <= 1'b0;
      head_q       <= '{pc: 32'h0, inst: NOP_INST};
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      head_valid_q <= head_valid_d;
      head_q       <= head_d;
    end
  end

  assign count_o      = count_q;
  assign head_valid_o = head_valid_q;
  assign head_o       = head_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch front end: owns the PC, runs req/ack fetches and feeds the IF/ID stage.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_data_i,
  input  logic        hazard_i,
  input  logic        flush_i,
  input  logic [31:0] target_i,
  output logic        valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  fetch_state_e     state_q, state_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic             req_q, req_d;
  logic [31:0]      addr_q, addr_d;
  logic             ack, push, pop, space;
  logic [CNT_W-1:0] count, count_next;
  logic             head_valid;
  fetch_entry_t     head;

  // Handshake, queue control and the space rule for issuing the next request.
  always_comb begin
    ack        = req_q & imem_ack_i;
    pop        = head_valid & ~hazard_i & ~flush_i;
    push       = (state_q == REQ) & ack & ~flush_i;
    count_next = count + CNT_W'(push) - CNT_W'(pop);
    space      = (count_next < CNT_W'(DEPTH));
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      req_q      <= 1'b0;
      addr_q     <= 32'h0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
    end
  end

  // Flush redirects the PC and turns an unfinished request into one whose data is dropped.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    if (flush_i) begin
      fetch_pc_d = target_i & ~32'h3;
      if (state_q != IDLE) begin
        state_d = ack ? IDLE : KILL;
      end
    end else begin
      unique case (state_q)
        IDLE: if (space) state_d = REQ;
        REQ: begin
          if (ack) begin
            fetch_pc_d = fetch_pc_q + PC_STEP;
            state_d    = space ? REQ : IDLE;
          end
        end
        KILL:    if (ack) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Address only moves when a fresh request starts; it is held while one is pending.
  always_comb begin
    req_d  = (state_d != IDLE);
    addr_d = addr_q;
    if ((state_d == REQ) && ((state_q != REQ) || ack)) begin
      addr_d = fetch_pc_d;
    end
  end

  if_fetch_unit_fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (push),
    .entry_i     ('{pc: fetch_pc_q, inst: imem_data_i}),
    .pop_i       (pop),
    .clear_i     (flush_i),
    .count_o     (count),
    .head_valid_o(head_valid),
    .head_o      (head)
  );

  assign imem_req_o  = req_q;
  assign imem_addr_o = addr_q;
  assign valid_o     = head_valid;
  assign pc_o        = head.pc;
  assign inst_o      = head.inst;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with a behavioural instruction memory and adjustable ack delay.
module tb_if_fetch_unit;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_data;
  logic        hazard = 1'b0, flush = 1'b0;
  logic [31:0] target = 32'h0;
  logic        valid;
  logic [31:0] pc, inst;

  logic        w_req, w_ack, w_valid;
  logic [31:0] w_addr, w_data, w_pc, w_inst;

  int n_checks = 0;
  int n_fail   = 0;
  int ack_delay = 0;
  int wait_cnt;

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  assign imem_data = mem_word(imem_addr);
  assign imem_ack  = imem_req && (wait_cnt >= ack_delay);
  assign w_data    = mem_word(w_addr);
  assign w_ack     = w_req;

  always @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) wait_cnt <= 0;
    else if (!imem_req || imem_ack) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
  end

  if_fetch_unit #(.DEPTH(2), .RESET_PC(32'h0000_0000)) u_dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .imem_req_o(imem_req), .imem_addr_o(imem_addr),
    .imem_ack_i(imem_ack), .imem_data_i(imem_data),
    .hazard_i(hazard), .flush_i(flush), .target_i(target),
    .valid_o(valid), .pc_o(pc), .inst_o(inst)
  );

  if_fetch_unit #(.DEPTH(2), .RESET_PC(32'hFFFF_FFF8)) u_dut_wrap (
    .clk_i(clk_i), .rst_i(rst_i),
    .imem_req_o(w_req), .imem_addr_o(w_addr),
    .imem_ack_i(w_ack), .imem_data_i(w_data),
    .hazard_i(1'b0), .flush_i(1'b0), .target_i(32'h0),
    .valid_o(w_valid), .pc_o(w_pc), .inst_o(w_inst)
  );

  task automatic test_reset();
    #2;
    n_checks++; if (imem_req !== 1'b0)      begin n_fail++; $display("FAIL reset_req: got %b want 0", imem_req); end
    n_checks++; if (imem_addr !== 32'h0)    begin n_fail++; $display("FAIL reset_addr: got %h want 0", imem_addr); end
    n_checks++; if (valid !== 1'b0)         begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid); end
    n_checks++; if (pc !== 32'h0)           begin n_fail++; $display("FAIL reset_pc: got %h want 0", pc); end
    n_checks++; if (inst !== 32'h0)         begin n_fail++; $display("FAIL reset_inst: got %h want 0", inst); end
    @(negedge clk_i);
    n_checks++; if (imem_req !== 1'b0)      begin n_fail++; $display("FAIL reset_held_req: got %b want 0", imem_req); end
    rst_i = 1'b1;
  endtask

  task automatic test_stream();
    logic [31:0] ea, ep;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk_i);
      ea = 32'(4 * (k - 1));
      n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL stream_req[%0d]: got %b want 1", k, imem_req); end
      n_checks++; if (imem_addr !== ea)  begin n_fail++; $display("FAIL stream_addr[%0d]: got %h want %h", k, imem_addr, ea); end
      if (k == 1) begin
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL stream_first_valid: got %b want 0", valid); end
        n_checks++; if (pc !== 32'h0)   begin n_fail++; $display("FAIL stream_first_pc: got %h want 0", pc); end
      end else begin
        ep = 32'(4 * (k - 2));
        n_checks++; if (valid !== 1'b1)       begin n_fail++; $display("FAIL stream_valid[%0d]: got %b want 1", k, valid); end
        n_checks++; if (pc !== ep)            begin n_fail++; $display("FAIL stream_pc[%0d]: got %h want %h", k, pc, ep); end
        n_checks++; if (inst !== mem_word(ep)) begin n_fail++; $display("FAIL stream_inst[%0d]: got %h want %h", k, inst, mem_word(ep)); end
      end
    end
  endtask

  task automatic test_hazard();
    logic [31:0] ep, ea;
    hazard = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      n_checks++; if (valid !== 1'b1)              begin n_fail++; $display("FAIL hazard_valid[%0d]: got %b want 1", i, valid); end
      n_checks++; if (pc !== 32'h10)               begin n_fail++; $display("FAIL hazard_pc[%0d]: got %h want 10", i, pc); end
      n_checks++; if (inst !== mem_word(32'h10))   begin n_fail++; $display("FAIL hazard_inst[%0d]: got %h want %h", i, inst, mem_word(32'h10)); end
      n_checks++; if (imem_req !== 1'b0)           begin n_fail++; $display("FAIL hazard_req_drop[%0d]: got %b want 0", i, imem_req); end
    end
    hazard = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk_i);
      ep = 32'(20 + 4 * j);
      ea = 32'(24 + 4 * j);
      n_checks++; if (pc !== ep)          begin n_fail++; $display("FAIL resume_pc[%0d]: got %h want %h", j, pc, ep); end
      n_checks++; if (imem_req !== 1'b1)  begin n_fail++; $display("FAIL resume_req[%0d]: got %b want 1", j, imem_req); end
      n_checks++; if (imem_addr !== ea)   begin n_fail++; $display("FAIL resume_addr[%0d]: got %h want %h", j, imem_addr, ea); end
    end
  endtask

  task automatic test_ack_delay();
    ack_delay = 3;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      n_checks++; if (valid !== 1'b0)        begin n_fail++; $display("FAIL wait_valid[%0d]: got %b want 0", i, valid); end
      n_checks++; if (pc !== 32'h0)          begin n_fail++; $display("FAIL wait_pc[%0d]: got %h want 0", i, pc); end
      n_checks++; if (inst !== 32'h0)        begin n_fail++; $display("FAIL wait_inst[%0d]: got %h want 0", i, inst); end
      n_checks++; if (imem_req !== 1'b1)     begin n_fail++; $display("FAIL wait_req[%0d]: got %b want 1", i, imem_req); end
      n_checks++; if (imem_addr !== 32'h20)  begin n_fail++; $display("FAIL wait_addr_stable[%0d]: got %h want 20", i, imem_addr); end
    end
    @(negedge clk_i);
    n_checks++; if (valid !== 1'b1)             begin n_fail++; $display("FAIL wait_done_valid: got %b want 1", valid); end
    n_checks++; if (pc !== 32'h20)              begin n_fail++; $display("FAIL wait_done_pc: got %h want 20", pc); end
    n_checks++; if (inst !== mem_word(32'h20))  begin n_fail++; $display("FAIL wait_done_inst: got %h want %h", inst, mem_word(32'h20)); end
    n_checks++; if (imem_addr !== 32'h24)       begin n_fail++; $display("FAIL wait_done_addr: got %h want 24", imem_addr); end
  endtask

  task automatic test_flush_inflight();
    ack_delay = 2;
    flush  = 1'b1;
    target = 32'h0000_0103;
    @(negedge clk_i);
    flush = 1'b0;
    n_checks++; if (valid !== 1'b0)        begin n_fail++; $display("FAIL flush_clear_valid: got %b want 0", valid); end
    n_checks++; if (pc !== 32'h0)          begin n_fail++; $display("FAIL flush_clear_pc: got %h want 0", pc); end
    n_checks++; if (inst !== 32'h0)        begin n_fail++; $display("FAIL flush_clear_inst: got %h want 0", inst); end
    n_checks++; if (imem_req !== 1'b1)     begin n_fail++; $display("FAIL kill_req_held: got %b want 1", imem_req); end
    n_checks++; if (imem_addr !== 32'h24)  begin n_fail++; $display("FAIL kill_addr_held: got %h want 24", imem_addr); end
    @(negedge clk_i);
    n_checks++; if (imem_req !== 1'b1)     begin n_fail++; $display("FAIL kill_req_wait: got %b want 1", imem_req); end
    n_checks++; if (valid !== 1'b0)        begin n_fail++; $display("FAIL kill_valid_wait: got %b want 0", valid); end
    @(negedge clk_i);
    n_checks++; if (imem_req !== 1'b0)     begin n_fail++; $display("FAIL kill_ack_req: got %b want 0", imem_req); end
    n_checks++; if (valid !== 1'b0)        begin n_fail++; $display("FAIL kill_discard_valid: got %b want 0", valid); end
    @(negedge clk_i);
    n_checks++; if (imem_req !== 1'b1)     begin n_fail++; $display("FAIL redirect_req: got %b want 1", imem_req); end
    n_checks++; if (imem_addr !== 32'h100) begin n_fail++; $display("FAIL redirect_addr: got %h want 100", imem_addr); end
    ack_delay = 0;
    @(negedge clk_i);
    n_checks++; if (valid !== 1'b1)             begin n_fail++; $display("FAIL redirect_valid: got %b want 1", valid); end
    n_checks++; if (pc !== 32'h100)             begin n_fail++; $display("FAIL redirect_pc: got %h want 100", pc); end
    n_checks++; if (inst !== mem_word(32'h100)) begin n_fail++; $display("FAIL redirect_inst: got %h want %h", inst, mem_word(32'h100)); end
    n_checks++; if (imem_addr !== 32'h104)      begin n_fail++; $display("FAIL redirect_next_addr: got %h want 104", imem_addr); end
  endtask

  task automatic test_flush_hazard_ack();
    flush  = 1'b1;
    hazard = 1'b1;
    target = 32'h0000_2000;
    @(negedge clk_i);
    flush = 1'b0;
    n_checks++; if (valid !== 1'b0)    begin n_fail++; $display("FAIL fha_valid: got %b want 0", valid); end
    n_checks++; if (pc !== 32'h0)      begin n_fail++; $display("FAIL fha_pc: got %h want 0", pc); end
    n_checks++; if (inst !== 32'h0)    begin n_fail++; $display("FAIL fha_inst: got %h want 0", inst); end
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL fha_req: got %b want 0", imem_req); end
    @(negedge clk_i);
    n_checks++; if (imem_req !== 1'b1)      begin n_fail++; $display("FAIL fha_refetch_req: got %b want 1", imem_req); end
    n_checks++; if (imem_addr !== 32'h2000) begin n_fail++; $display("FAIL fha_refetch_addr: got %h want 2000", imem_addr); end
    n_checks++; if (valid !== 1'b0)         begin n_fail++; $display("FAIL empty_hazard_valid: got %b want 0", valid); end
    n_checks++; if (pc !== 32'h0)           begin n_fail++; $display("FAIL empty_hazard_pc: got %h want 0", pc); end
    hazard = 1'b0;
    @(negedge clk_i);
    n_checks++; if (valid !== 1'b1)              begin n_fail++; $display("FAIL fha_head_valid: got %b want 1", valid); end
    n_checks++; if (pc !== 32'h2000)             begin n_fail++; $display("FAIL fha_head_pc: got %h want 2000", pc); end
    n_checks++; if (inst !== mem_word(32'h2000)) begin n_fail++; $display("FAIL fha_head_inst: got %h want %h", inst, mem_word(32'h2000)); end
    n_checks++; if (imem_addr !== 32'h2004)      begin n_fail++; $display("FAIL fha_next_addr: got %h want 2004", imem_addr); end
  endtask

  task automatic test_async_reset();
    ack_delay = 5;
    @(negedge clk_i);
    n_checks++; if (imem_req !== 1'b1)      begin n_fail++; $display("FAIL pre_arst_req: got %b want 1", imem_req); end
    n_checks++; if (imem_addr !== 32'h2004) begin n_fail++; $display("FAIL pre_arst_addr: got %h want 2004", imem_addr); end
    n_checks++; if (valid !== 1'b0)         begin n_fail++; $display("FAIL pre_arst_valid: got %b want 0", valid); end
    #1 rst_i = 1'b0;
    #1;
    n_checks++; if (imem_req !== 1'b0)   begin n_fail++; $display("FAIL arst_req: got %b want 0", imem_req); end
    n_checks++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL arst_addr: got %h want 0", imem_addr); end
    n_checks++; if (w_req !== 1'b0)      begin n_fail++; $display("FAIL arst_wrap_req: got %b want 0", w_req); end
    ack_delay = 0;
    @(negedge clk_i);
    n_checks++; if (imem_req !== 1'b0)   begin n_fail++; $display("FAIL arst_held_req: got %b want 0", imem_req); end
  endtask

  task automatic test_reset_pc_wrap();
    logic [31:0] ea, ep;
    rst_i = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk_i);
      ea = 32'hFFFF_FFF8 + 32'(4 * (k - 1));
      n_checks++; if (w_req !== 1'b1) begin n_fail++; $display("FAIL wrap_req[%0d]: got %b want 1", k, w_req); end
      n_checks++; if (w_addr !== ea)  begin n_fail++; $display("FAIL wrap_addr[%0d]: got %h want %h", k, w_addr, ea); end
      if (k == 1) begin
        n_checks++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL rerun_addr: got %h want 0", imem_addr); end
      end else begin
        ep = 32'hFFFF_FFF8 + 32'(4 * (k - 2));
        n_checks++; if (w_valid !== 1'b1)        begin n_fail++; $display("FAIL wrap_valid[%0d]: got %b want 1", k, w_valid); end
        n_checks++; if (w_pc !== ep)             begin n_fail++; $display("FAIL wrap_pc[%0d]: got %h want %h", k, w_pc, ep); end
        n_checks++; if (w_inst !== mem_word(ep)) begin n_fail++; $display("FAIL wrap_inst[%0d]: got %h want %h", k, w_inst, mem_word(ep)); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_hazard();
    test_ack_delay();
    test_flush_inflight();
    test_flush_hazard_ack();
    test_async_reset();
    test_reset_pc_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
